csa_serial_resolver: RTL



---
 rtl/csa_serial_resolver_if.sv | 22 ++
 rtl/csa_serial_resolver.sv | 122 ++++++++++++
 2 files changed

// File: rtl/csa_serial_resolver_if.sv
// Handshake bundle between CSA operand logic, the serial resolver and its result consumer.
interface csa_serial_resolver_if #(
  parameter int WIDTH = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   sv;
  logic [WIDTH-1:0]   cv;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH+1:0]   result;

  modport master (
    output in_valid, sv, cv, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, sv, cv, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/csa_serial_resolver.sv
// Resolves a carry-save pair (sv, cv) to binary with a bit-serial ripple adder, one bit per clock.
// Define CSR_PARALLEL_EN to replace the serial adder with a single-cycle full-width add.
module csa_serial_resolver #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  csa_serial_resolver_if.slave bus
);
  localparam int RW = WIDTH + 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [RW-1:0] result_q, result_d;
  logic [RW-1:0] a_q, a_d;
  logic [RW-1:0] b_q, b_d;

`ifndef CSR_PARALLEL_EN
  localparam int CW = $clog2(RW + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(RW - 1);

  logic          carry_q, carry_d;
  logic [CW-1:0] count_q, count_d;
  logic          sum_bit;
`endif

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    a_d         = a_q;
    b_d         = b_q;
`ifndef CSR_PARALLEL_EN
    carry_d     = carry_q;
    count_d     = count_q;
    sum_bit     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        // in_ready is registered so it only rises on the first edge after reset release
        in_ready_d = 1'b1;
        if (bus.in_valid && in_ready_q) begin
          a_d        = {2'b00, bus.sv};
          b_d        = {1'b0, bus.cv, 1'b0};
          in_ready_d = 1'b0;
          state_d    = S_CALC;
`ifndef CSR_PARALLEL_EN
          carry_d    = 1'b0;
          count_d    = '0;
`endif
        end
      end
      S_CALC: begin
`ifdef CSR_PARALLEL_EN
        result_d    = a_q + b_q;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
`else
        sum_bit  = a_q[0] ^ b_q[0] ^ carry_q;
        carry_d  = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        // LSB is computed first, so after RW shifts it lands in result[0]
        result_d = {sum_bit, result_q[RW-1:1]};
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        count_d  = count_q + CW'(1);
        if (count_q == LAST_BIT) begin
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
`endif
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
`ifndef CSR_PARALLEL_EN
      carry_q     <= 1'b0;
      count_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      a_q         <= a_d;
      b_q         <= b_d;
`ifndef CSR_PARALLEL_EN
      carry_q     <= carry_d;
      count_q     <= count_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
endmodule
